// File: rtl/rotr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rotr_pkg
//  Description : Shared constants for the serial rotate unit: default
//                geometry, FSM state encodings and a log2 helper used to
//                size the rotate-amount and step-amount fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package rotr_pkg;

    // Default geometry
    localparam int ROTR_WIDTH = 32;
    localparam int ROTR_STEP  = 1;

    // FSM state encodings (IDLE, BUSY, DONE)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Smallest r such that 2**r >= v; sizes the amt field (v = WIDTH)
    // and the per-cycle step field (v = STEP + 1).
    function automatic int rotr_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : rotr_pkg
`default_nettype wire

// File: rtl/rotr_step.sv
`default_nettype none
// ============================================================================
//  Module      : rotr_step
//  Description : Combinational rotate of one word by a small amount s
//                (0..STEP). Rotates right; with ROTR_DIR_EN defined a dir
//                input selects left rotation when high.
//  Revision    : 1.0 - initial release
// ============================================================================
module rotr_step #(
    parameter int WIDTH = 32,
    parameter int SW    = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SW-1:0]    s_i,
`ifdef ROTR_DIR_EN
    input  logic             dir_i,
`endif
    output logic [WIDTH-1:0] data_o
);

    // Complementary shift distance; a shift by WIDTH yields zero, which
    // makes s_i == 0 return the word unchanged without a special case.
    int w_back;

    // Rotate as the OR of two opposite logical shifts
    always_comb begin
        w_back = WIDTH - int'(s_i);
`ifdef ROTR_DIR_EN
        if (dir_i) begin
            data_o = (data_i << s_i) | (data_i >> w_back);
        end else begin
            data_o = (data_i >> s_i) | (data_i << w_back);
        end
`else
        data_o = (data_i >> s_i) | (data_i << w_back);
`endif
    end

endmodule : rotr_step
`default_nettype wire

// File: rtl/rotr_serial.sv
`default_nettype none
// ============================================================================
//  Module      : rotr_serial
//  Description : Sequential rotate-right of a WIDTH-bit word, up to STEP
//                bits per clock, with valid/ready handshakes on both sides.
//                Optional macro ROTR_DIR_EN adds a dir input (1 = left).
//  Revision    : 1.0 - initial release
// ============================================================================
module rotr_serial
    import rotr_pkg::*;
#(
    parameter int WIDTH = ROTR_WIDTH,
    parameter int STEP  = ROTR_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] k,
`ifdef ROTR_DIR_EN
    input  logic             dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o
);

    localparam int             AW       = rotr_log2(WIDTH);
    localparam int             SW       = rotr_log2(STEP + 1);
    localparam logic [AW:0]    STEP_EXT = (AW + 1)'(STEP);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [AW-1:0]    amt_q,   amt_d;
    logic             dir_q,   dir_d;

    logic             w_accept;
    logic             w_step_full;
    logic [SW-1:0]    w_s;
    logic [WIDTH-1:0] w_rot;
    logic             w_unused_k;

    // Only k mod WIDTH matters; the upper bits are intentionally dropped.
    assign w_unused_k = ^k[WIDTH-1:AW];

    // Handshake and result outputs decode directly from state so a reset
    // clears them in the same instant.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
        o         = (state_q == ST_DONE) ? data_q : '0;
        w_accept  = in_valid && in_ready;
    end

    // Per-cycle rotate amount: min(STEP, amt)
    always_comb begin
        w_step_full = ({1'b0, amt_q} >= STEP_EXT);
        w_s         = w_step_full ? SW'(STEP) : SW'(amt_q);
    end

    rotr_step #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_step (
        .data_i (data_q),
        .s_i    (w_s),
`ifdef ROTR_DIR_EN
        .dir_i  (dir_q),
`endif
        .data_o (w_rot)
    );

    // Next-state logic; acceptance (from IDLE or back-to-back from DONE)
    // overrides whatever the state case decided.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        amt_d   = amt_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_BUSY: begin
                data_d = w_rot;
                amt_d  = amt_q - AW'(w_s);
                if (amt_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (w_accept) begin
            data_d  = x;
            amt_d   = k[AW-1:0];
`ifdef ROTR_DIR_EN
            dir_d   = dir;
`else
            dir_d   = 1'b0;
`endif
            state_d = (k[AW-1:0] == '0) ? ST_DONE : ST_BUSY;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            amt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            dir_q   <= dir_d;
        end
    end

`ifndef ROTR_DIR_EN
    logic w_unused_dir;
    assign w_unused_dir = dir_q;
`endif

endmodule : rotr_serial
`default_nettype wire
